// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces the start/stop and lap/reset keys and sequences
// the counter through idle/run/lap/pause. The LAP state is built only when LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned          CNT_W           = 20,
  parameter logic [CNT_W-1:0]     DEBOUNCE_CYCLES = 20'd999999
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       key_ss_n,
  input  logic       key_lr_n,
  output logic       run,
  output logic       clr,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
`ifdef LAP_EN
    ST_LAP   = 2'b10,
`endif
    ST_PAUSE = 2'b11
  } state_e;

  // Key index 0 is start/stop, index 1 is lap/reset.
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       db_q, db_d;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   clr_q, clr_d;

  always_comb begin
    s1_d    = {key_lr_n, key_ss_n};
    s2_d    = s1_q;
    db_d    = db_q;
    press_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYCLES) begin
          db_d[i]    = s2_q[i];
          // Only a debounced 1->0 edge is a press; releases produce no event.
          press_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '1;
      s2_q    <= '1;
      db_q    <= '1;
      press_q <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start/stop is evaluated first so a simultaneous lap/reset press is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (press_q[0]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
`ifdef LAP_EN
        ST_LAP:   state_d = ST_PAUSE;
`endif
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (press_q[1]) begin
      case (state_q)
        ST_IDLE:  clr_d = 1'b1;
        ST_RUN: begin
`ifdef LAP_EN
          state_d = ST_LAP;
`endif
        end
`ifdef LAP_EN
        ST_LAP:   state_d = ST_RUN;
`endif
        ST_PAUSE: begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
`ifdef LAP_EN
    run_d = (state_d == ST_RUN) || (state_d == ST_LAP);
`else
    run_d = (state_d == ST_RUN);
`endif
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
    end
  end

`ifdef LAP_EN
  logic lap_hold_q, lap_hold_d;

  always_comb lap_hold_d = (state_d == ST_LAP);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) lap_hold_q <= 1'b0;
    else        lap_hold_q <= lap_hold_d;
  end

  assign lap_hold = lap_hold_q;
`else
  assign lap_hold = 1'b0;
`endif

  assign run   = run_q;
  assign clr   = clr_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against a window-based behavioural model.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic       key_ss_n;
  logic       key_lr_n;
  logic       run;
  logic       clr;
  logic       lap_hold;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  stopwatch_ctrl #(.CNT_W(3), .DEBOUNCE_CYCLES(3'd4)) dut (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .key_ss_n (key_ss_n),
    .key_lr_n (key_lr_n),
    .run      (run),
    .clr      (clr),
    .lap_hold (lap_hold),
    .state    (state)
  );

  always #5 mclk = ~mclk;

  // Model: raw key history since reset; a debounced level flips when the
  // D+1 synchronized samples (raw delayed by two edges) all differ from it.
  bit hss[$];
  bit hlr[$];
  bit mdb[2];
  bit mpress[2];
  int mst;
  bit mclr;

  function automatic bit hval(input int which, input int idx);
    if (idx < 0) return 1'b1;
    return (which == 0) ? hss[idx] : hlr[idx];
  endfunction

  function automatic void model_reset();
    hss.delete();
    hlr.delete();
    mdb[0] = 1'b1; mdb[1] = 1'b1;
    mpress[0] = 1'b0; mpress[1] = 1'b0;
    mst  = 0;
    mclr = 1'b0;
  endfunction

  function automatic void model_edge();
    int  n;
    bit  flip;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mclr = 1'b0;
    if (mpress[0]) begin
      if (mst == 0 || mst == 3) mst = 1;
      else                      mst = 3;
    end else if (mpress[1]) begin
      case (mst)
        0: mclr = 1'b1;
`ifdef LAP_EN
        1: mst = 2;
`endif
        2: mst = 1;
        3: begin mst = 0; mclr = 1'b1; end
        default: ;
      endcase
    end
    hss.push_back(key_ss_n);
    hlr.push_back(key_lr_n);
    n = hss.size();
    for (int k = 0; k < 2; k++) begin
      flip = 1'b1;
      for (int i = 0; i <= D; i++)
        if (hval(k, n - 3 - i) == mdb[k]) flip = 1'b0;
      mpress[k] = flip && mdb[k];
      if (flip) mdb[k] = ~mdb[k];
    end
  endfunction

  function automatic logic [4:0] model_out();
    logic [1:0] s;
    s = mst[1:0];
    return {s, (mst == 1 || mst == 2), mclr, (mst == 2)};
  endfunction

  function automatic logic [4:0] dut_out();
    return {state, run, clr, lap_hold};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: {state,run,clr,lap_hold} got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge();
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic press(input int which);
    if (which == 0) key_ss_n = 1'b0; else key_lr_n = 1'b0;
    repeat (8) tick();
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
    repeat (10) tick();
  endtask

  typedef struct {
    bit          ss;
    bit          lr;
    int unsigned cycles;
    logic [4:0]  exp;
  } vec_t;

  function automatic vec_t mk(input bit ss, input bit lr, input int unsigned c, input logic [4:0] e);
    vec_t v;
    v.ss = ss; v.lr = lr; v.cycles = c; v.exp = e;
    return v;
  endfunction

  vec_t vecs[$];
  int   len_ss, len_lr;

  initial begin
    // Expected encoding: {state[1:0], run, clr, lap_hold}
    vecs.push_back(mk(0, 1, 7,  5'b00_0_0_0));
    vecs.push_back(mk(0, 1, 1,  5'b01_1_0_0));
    vecs.push_back(mk(0, 1, 10, 5'b01_1_0_0));
    vecs.push_back(mk(1, 1, 10, 5'b01_1_0_0));
    vecs.push_back(mk(0, 1, 3,  5'b01_1_0_0));
    vecs.push_back(mk(1, 1, 6,  5'b01_1_0_0));
    vecs.push_back(mk(0, 1, 7,  5'b01_1_0_0));
    vecs.push_back(mk(0, 1, 1,  5'b11_0_0_0));
    vecs.push_back(mk(1, 1, 10, 5'b11_0_0_0));
    vecs.push_back(mk(1, 0, 7,  5'b11_0_0_0));
    vecs.push_back(mk(1, 0, 1,  5'b00_0_1_0));
    vecs.push_back(mk(1, 0, 1,  5'b00_0_0_0));
    vecs.push_back(mk(1, 1, 10, 5'b00_0_0_0));
    vecs.push_back(mk(1, 0, 7,  5'b00_0_0_0));
    vecs.push_back(mk(1, 0, 1,  5'b00_0_1_0));
    vecs.push_back(mk(1, 0, 1,  5'b00_0_0_0));
    vecs.push_back(mk(1, 1, 10, 5'b00_0_0_0));
    vecs.push_back(mk(0, 0, 7,  5'b00_0_0_0));
    vecs.push_back(mk(0, 0, 1,  5'b01_1_0_0));
    vecs.push_back(mk(0, 0, 5,  5'b01_1_0_0));
    vecs.push_back(mk(1, 1, 10, 5'b01_1_0_0));

    rst_n    = 1'b0;
    key_ss_n = 1'b1;
    key_lr_n = 1'b1;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    chk("reset_values", dut_out(), 5'b00_0_0_0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      key_ss_n = vecs[i].ss;
      key_lr_n = vecs[i].lr;
      repeat (vecs[i].cycles) tick();
      chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

`ifdef LAP_EN
    press(1);
    chk("lap_enter", dut_out(), 5'b10_1_0_1);
    press(1);
    chk("lap_release", dut_out(), 5'b01_1_0_0);
    press(1);
    chk("lap_again", dut_out(), 5'b10_1_0_1);
    press(0);
    chk("lap_to_pause", dut_out(), 5'b11_0_0_0);
    press(0);
    chk("pause_to_run", dut_out(), 5'b01_1_0_0);
`else
    press(1);
    chk("lr_ignored_in_run", dut_out(), 5'b01_1_0_0);
`endif

    // Asynchronous reset mid-debounce with SS still held through release.
    key_ss_n = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_out(), 5'b00_0_0_0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (7) tick();
    chk("held_at_release_wait", dut_out(), 5'b00_0_0_0);
    tick();
    chk("held_at_release_press", dut_out(), 5'b01_1_0_0);
    key_ss_n = 1'b1;
    repeat (10) tick();

    len_ss = 0;
    len_lr = 0;
    for (int t = 0; t < 3000; t++) begin
      if (len_ss == 0) begin
        key_ss_n = 1'($urandom_range(0, 1));
        len_ss   = $urandom_range(1, 12);
      end
      if (len_lr == 0) begin
        key_lr_n = 1'($urandom_range(0, 1));
        len_lr   = $urandom_range(1, 12);
      end
      len_ss--;
      len_lr--;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_reset", dut_out(), 5'b00_0_0_0);
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the mm:ss stopwatch counter. It debounces two raw active-low push-buttons: start/stop (SS) and lap/reset (LR). It sequences the counter through idle, run, lap and pause. It drives the counter's count-enable and synchronous clear, plus a display-freeze flag for lap capture. It sits between the board key pins and the seconds/minutes counter and display mux.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 20'd999999 (20 ms at 50 MHz): number of cycles a synchronized key level must stay stable before it is accepted. Minimum 1.
- CNT_W, default 20: debounce counter width. Must hold DEBOUNCE_CYCLES.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- key_ss_n  in  1  raw start/stop button; asynchronous, active-low.
- key_lr_n  in  1  raw lap/reset button; asynchronous, active-low.
- run  out  1  counter count-enable; level.
- clr  out  1  counter synchronous clear; one-cycle pulse.
- lap_hold  out  1  display freeze; 1 = display shows the latched lap value.
- state  out  2  current state: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE.

## Operation
- Each key has its own 2-FF synchronizer (s1→s2), debounced level db, counter cnt and registered press pulse.
- Debounce rules:
  - s2 == db → cnt <= 0.
  - s2 != db and cnt < DEBOUNCE_CYCLES → cnt <= cnt+1.
  - s2 != db and cnt == DEBOUNCE_CYCLES → db <= s2, cnt <= 0.
- Press rules:
  - press <= 1 for exactly one cycle when db goes 1→0.
  - A release (db 0→1) generates no event.
- FSM transitions (evaluated on press pulses):
  - IDLE: SS → RUN. LR → stay IDLE, pulse clr.
  - RUN: SS → PAUSE. LR → LAP.
  - LAP: LR → RUN (release freeze). SS → PAUSE (lap_hold cleared).
  - PAUSE: SS → RUN. LR → IDLE, pulse clr.
- Outputs by state:
  - run = 1 in RUN and LAP; 0 in IDLE and PAUSE.
  - lap_hold = 1 only in LAP.
- Simultaneous SS and LR presses in the same cycle: SS wins and the LR press is discarded.
- All outputs are registered.

## Timing
- Reset values:
  - state = IDLE (00), run = 0, clr = 0, lap_hold = 0.
  - s1/s2/db = 1, cnt = 0, press = 0.
- Latency, with the raw key held low from before rising edge 1:
  - Edge 2: s2 = 0.
  - Edge 2+D: cnt = D, where D = DEBOUNCE_CYCLES.
  - Edge 3+D: db = 0 and press is asserted.
  - Edge 4+D: state, run and lap_hold update, and clr asserts.
- clr deasserts one edge after it asserts (exactly 1 cycle wide).
- A key low for fewer than D+1 consecutive s2 cycles produces no event. Any bounce back to 1 resets cnt to 0.
- A held key generates one event only. A new event requires a debounced release followed by a new debounced press.
- The two keys are fully independent. Both keys can be mid-debounce at the same time.
- rst_n asserted mid-debounce or mid-state discards everything and returns to the reset values immediately (asynchronous). No event is produced from a key still held at reset release until it is debounced high then low again: db resets to 1, so a held key is seen as a new press after D+4 edges. This held-key-at-reset-release case is deliberate and must be tested.

## Configuration
- LAP_EN defined:
  - Full behaviour as above, including the LAP state and lap_hold.
- LAP_EN undefined:
  - The LAP state is not built and lap_hold is tied to 0.
  - An LR press in RUN is ignored.
  - LR in IDLE and PAUSE behaves unchanged.
  - state never reads 10.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3, LAP_EN defined unless noted.
1. Reset, then hold key_ss_n low → run=1 and state=01 at edge 8 after the first low sample; clr stays 0.
2. From RUN: pulse key_ss_n low for 3 cycles (bounce), then release → no change. Then hold SS ≥5 cycles → state=11, run=0.
3. From PAUSE: press LR → state=00, run=0, and clr=1 for exactly one cycle. Press LR again in IDLE → another single clr pulse, state stays 00.
4. RUN: press LR → state=10, lap_hold=1, run=1. Press LR → state=01, lap_hold=0. Press LR then SS → state=11, lap_hold=0.
5. Both keys driven low on the same edge from IDLE → only RUN is entered; no clr pulse and no LAP entry.
6. LAP_EN undefined: press LR in RUN → state stays 01, lap_hold=0. Also assert rst_n mid-debounce → all outputs return to 0 / IDLE at once.
